mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the shared 32x8 program/data memory of the RISC core. It sequences every memory cycle, serialising requests from the CPU controller and a debug/program loader port. For each request it drives address, read/write strobes and tristate enable for a fixed number of cycles, captures read data, and returns a one-cycle acknowledge to the owner. Arbitration is round-robin or CPU-fixed-priority.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared program/data memory.
// Serialises CPU and loader requests into fixed-length memory cycles with one-cycle acks.
module mem_arbiter #(
    parameter int unsigned AW           = 5,
    parameter int unsigned DW           = 8,
    parameter int unsigned ACC_CYCLES   = 1,
    parameter int unsigned CPU_PRIORITY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_oe,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [3:0] CntInit = 4'(ACC_CYCLES - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          last_owner_q, last_owner_d;
    logic          grant_ld;
    logic          capture;

    // On a tie the loader wins only in round-robin mode when the CPU was served last.
    assign grant_ld = ld_req && (!cpu_req || (CPU_PRIORITY == 0 && !last_owner_q));
    assign capture  = (state_q == StAccess) && (cnt_q == '0) && !wr_q;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_owner_d = last_owner_q;
        case (state_q)
            StIdle: begin
                if (cpu_req || ld_req) begin
                    state_d      = StAccess;
                    cnt_d        = CntInit;
                    owner_d      = grant_ld;
                    last_owner_d = grant_ld;
                    wr_d         = grant_ld ? ld_wr : cpu_wr;
                    addr_d       = grant_ld ? ld_addr : cpu_addr;
                    wdata_d      = grant_ld ? ld_wdata : cpu_wdata;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes and acks are registered from the next-state values so every output is a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_owner_q <= 1'b1;
            busy         <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_oe       <= 1'b0;
            cpu_ack      <= 1'b0;
            ld_ack       <= 1'b0;
            cpu_rdata    <= '0;
            ld_rdata     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_owner_q <= last_owner_d;
            busy         <= (state_d != StIdle);
            mem_rd       <= (state_d == StAccess) && !wr_d;
            mem_oe       <= (state_d == StAccess) && wr_d;
            mem_wr       <= (state_d == StAccess) && wr_d && (cnt_d == '0);
            cpu_ack      <= (state_d == StDone) && !owner_d;
            ld_ack       <= (state_d == StDone) && owner_d;
            if (capture && !owner_q) begin
                cpu_rdata <= mem_rdata;
            end
            if (capture && owner_q) begin
                ld_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance (ACC_CYCLES=3) and a fixed-priority
// instance (ACC_CYCLES=1), each backed by a behavioural 32x8 memory.
module tb_mem_arbiter;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int RACC = 3;
    localparam int FACC = 1;
    localparam int RPER = RACC + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Round-robin instance
    logic          r_cpu_req = 1'b0, r_cpu_wr = 1'b0, r_ld_req = 1'b0, r_ld_wr = 1'b0;
    logic [AW-1:0] r_cpu_addr = '0, r_ld_addr = '0, r_mem_addr;
    logic [DW-1:0] r_cpu_wdata = '0, r_ld_wdata = '0;
    logic [DW-1:0] r_cpu_rdata, r_ld_rdata, r_mem_wdata, r_mem_rdata;
    logic          r_cpu_ack, r_ld_ack, r_mem_rd, r_mem_wr, r_mem_oe, r_busy, r_owner;
    logic [DW-1:0] r_mem [32] = '{default: '0};

    assign r_mem_rdata = r_mem[r_mem_addr];
    always @(posedge clk) if (r_mem_wr && r_mem_oe) r_mem[r_mem_addr] <= r_mem_wdata;

    mem_arbiter #(.AW(AW), .DW(DW), .ACC_CYCLES(RACC), .CPU_PRIORITY(0)) u_rr (
        .clk(clk), .rst(rst),
        .cpu_req(r_cpu_req), .cpu_wr(r_cpu_wr), .cpu_addr(r_cpu_addr), .cpu_wdata(r_cpu_wdata),
        .cpu_ack(r_cpu_ack), .cpu_rdata(r_cpu_rdata),
        .ld_req(r_ld_req), .ld_wr(r_ld_wr), .ld_addr(r_ld_addr), .ld_wdata(r_ld_wdata),
        .ld_ack(r_ld_ack), .ld_rdata(r_ld_rdata),
        .mem_addr(r_mem_addr), .mem_rd(r_mem_rd), .mem_wr(r_mem_wr), .mem_wdata(r_mem_wdata),
        .mem_oe(r_mem_oe), .mem_rdata(r_mem_rdata), .busy(r_busy), .owner(r_owner)
    );

    // Fixed-priority instance
    logic          f_cpu_req = 1'b0, f_cpu_wr = 1'b0, f_ld_req = 1'b0, f_ld_wr = 1'b0;
    logic [AW-1:0] f_cpu_addr = '0, f_ld_addr = '0, f_mem_addr;
    logic [DW-1:0] f_cpu_wdata = '0, f_ld_wdata = '0;
    logic [DW-1:0] f_cpu_rdata, f_ld_rdata, f_mem_wdata, f_mem_rdata;
    logic          f_cpu_ack, f_ld_ack, f_mem_rd, f_mem_wr, f_mem_oe, f_busy, f_owner;
    logic [DW-1:0] f_mem [32] = '{default: '0};
    logic          f_pl_en = 1'b0;
    logic [AW-1:0] f_pl_addr = '0;
    logic [DW-1:0] f_pl_data = '0;

    assign f_mem_rdata = f_mem[f_mem_addr];
    always @(posedge clk) begin
        if (f_pl_en) f_mem[f_pl_addr] <= f_pl_data;
        else if (f_mem_wr && f_mem_oe) f_mem[f_mem_addr] <= f_mem_wdata;
    end

    mem_arbiter #(.AW(AW), .DW(DW), .ACC_CYCLES(FACC), .CPU_PRIORITY(1)) u_fp (
        .clk(clk), .rst(rst),
        .cpu_req(f_cpu_req), .cpu_wr(f_cpu_wr), .cpu_addr(f_cpu_addr), .cpu_wdata(f_cpu_wdata),
        .cpu_ack(f_cpu_ack), .cpu_rdata(f_cpu_rdata),
        .ld_req(f_ld_req), .ld_wr(f_ld_wr), .ld_addr(f_ld_addr), .ld_wdata(f_ld_wdata),
        .ld_ack(f_ld_ack), .ld_rdata(f_ld_rdata),
        .mem_addr(f_mem_addr), .mem_rd(f_mem_rd), .mem_wr(f_mem_wr), .mem_wdata(f_mem_wdata),
        .mem_oe(f_mem_oe), .mem_rdata(f_mem_rdata), .busy(f_busy), .owner(f_owner)
    );

    // Reference model for the round-robin instance: memory contents, per-port read data
    // and the port granted most recently.
    logic [DW-1:0] model_mem [32] = '{default: '0};
    logic [DW-1:0] m_rdata [2] = '{default: '0};
    bit            m_last = 1'b1;

    task automatic r_drive(input bit p, input bit req, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (p) begin
            r_ld_req = req; r_ld_wr = wr; r_ld_addr = a; r_ld_wdata = d;
        end else begin
            r_cpu_req = req; r_cpu_wr = wr; r_cpu_addr = a; r_cpu_wdata = d;
        end
    endtask

    task automatic r_set_req(input bit p, input bit v);
        if (p) r_ld_req = v;
        else r_cpu_req = v;
    endtask

    task automatic model_complete(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                  input bit p);
        if (wr) model_mem[a] = d;
        else m_rdata[p] = model_mem[a];
    endtask

    // One arbitration round on the round-robin instance, starting from IDLE.
    task automatic r_run(input bit want0, input bit want1, input bit wr0, input bit wr1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bit want [2];
        bit wr [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int grant_t [2];
        int ack_t [2];
        bit first;
        want[0] = want0; want[1] = want1; wr[0] = wr0; wr[1] = wr1;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        first = (want0 && want1) ? !m_last : want1;
        grant_t[first]  = 1;
        ack_t[first]    = RACC + 1;
        grant_t[!first] = want[!first] ? RACC + 3 : -1;
        ack_t[!first]   = want[!first] ? 2 * RACC + 3 : -1;
        m_last = want[!first] ? !first : first;
        @(negedge clk);
        for (int p = 0; p < 2; p++) if (want[p]) r_drive(p[0], 1'b1, wr[p], a[p], d[p]);
        for (int t = 1; t <= 2 * RACC + 4; t++) begin
            @(negedge clk);
            n_checks++;
            if ({r_cpu_ack, r_ld_ack} !== {ack_t[0] == t, ack_t[1] == t}) begin
                n_fail++;
                $display("FAIL run_acks t=%0d: got %b expected %b", t, {r_cpu_ack, r_ld_ack},
                         {ack_t[0] == t, ack_t[1] == t});
            end
            for (int p = 0; p < 2; p++) begin
                if (grant_t[p] == t) begin
                    n_checks++;
                    if ({r_owner, r_busy, r_mem_addr, r_mem_rd, r_mem_oe} !==
                        {p[0], 1'b1, a[p], !wr[p], wr[p]}) begin
                        n_fail++;
                        $display("FAIL run_grant port=%0d: got %b expected %b", p,
                                 {r_owner, r_busy, r_mem_addr, r_mem_rd, r_mem_oe},
                                 {p[0], 1'b1, a[p], !wr[p], wr[p]});
                    end
                    // Inputs change after the grant; the latched request must not.
                    r_drive(p[0], 1'b1, 1'($urandom_range(1, 0)), AW'($urandom_range(31, 0)),
                            DW'($urandom));
                end
                if (ack_t[p] == t) begin
                    model_complete(wr[p], a[p], d[p], p[0]);
                    n_checks++;
                    if ({r_cpu_rdata, r_ld_rdata} !== {m_rdata[0], m_rdata[1]}) begin
                        n_fail++;
                        $display("FAIL run_rdata port=%0d: got %h expected %h", p,
                                 {r_cpu_rdata, r_ld_rdata}, {m_rdata[0], m_rdata[1]});
                    end
                    r_set_req(p[0], 1'b0);
                end
            end
        end
        r_cpu_req = 1'b0;
        r_ld_req  = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({r_cpu_ack, r_ld_ack, r_mem_rd, r_mem_wr, r_mem_oe, r_busy, r_owner,
             f_cpu_ack, f_ld_ack, f_mem_rd, f_mem_wr, f_mem_oe, f_busy, f_owner} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected all 0",
                     {r_cpu_ack, r_ld_ack, r_mem_rd, r_mem_wr, r_mem_oe, r_busy, r_owner,
                      f_cpu_ack, f_ld_ack, f_mem_rd, f_mem_wr, f_mem_oe, f_busy, f_owner});
        end
        n_checks++;
        if ({r_cpu_rdata, r_ld_rdata, r_mem_addr, r_mem_wdata,
             f_cpu_rdata, f_ld_rdata, f_mem_addr, f_mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {r_cpu_rdata, r_ld_rdata, r_mem_addr, r_mem_wdata,
                      f_cpu_rdata, f_ld_rdata, f_mem_addr, f_mem_wdata});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({r_busy, f_busy, r_cpu_ack, r_ld_ack} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected 0000",
                     {r_busy, f_busy, r_cpu_ack, r_ld_ack});
        end
    endtask

    task automatic test_single_read();
        logic [5:0] ev [3];
        ev[0] = 6'b100100; ev[1] = 6'b000110; ev[2] = 6'b000000;
        @(negedge clk);
        f_pl_en = 1'b1; f_pl_addr = 5'h03; f_pl_data = 8'h5A;
        @(negedge clk);
        f_pl_en = 1'b0;
        f_cpu_req = 1'b1; f_cpu_wr = 1'b0; f_cpu_addr = 5'h03;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            n_checks++;
            if ({f_mem_rd, f_mem_wr, f_mem_oe, f_busy, f_cpu_ack, f_ld_ack} !== ev[t]) begin
                n_fail++;
                $display("FAIL single_read t=%0d: got %b expected %b", t,
                         {f_mem_rd, f_mem_wr, f_mem_oe, f_busy, f_cpu_ack, f_ld_ack}, ev[t]);
            end
            n_checks++;
            if (t == 0 && f_mem_addr !== 5'h03 || t > 0 && f_cpu_rdata !== 8'h5A) begin
                n_fail++;
                $display("FAIL single_read_data t=%0d: got addr %h rdata %h expected 03/5A", t,
                         f_mem_addr, f_cpu_rdata);
            end
            if (t == 1) f_cpu_req = 1'b0;
        end
    endtask

    task automatic test_loader_write();
        logic [5:0] ev [4];
        ev[0] = 6'b001100; ev[1] = 6'b001100; ev[2] = 6'b011100; ev[3] = 6'b000101;
        @(negedge clk);
        r_drive(1'b1, 1'b1, 1'b1, 5'h1F, 8'hC3);
        m_last = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            n_checks++;
            if ({r_mem_rd, r_mem_wr, r_mem_oe, r_busy, r_cpu_ack, r_ld_ack} !== ev[t]) begin
                n_fail++;
                $display("FAIL ld_write t=%0d: got %b expected %b", t,
                         {r_mem_rd, r_mem_wr, r_mem_oe, r_busy, r_cpu_ack, r_ld_ack}, ev[t]);
            end
            if (t < 3) begin
                n_checks++;
                if ({r_owner, r_mem_addr, r_mem_wdata} !== {1'b1, 5'h1F, 8'hC3}) begin
                    n_fail++;
                    $display("FAIL ld_write_bus t=%0d: got %h expected %h", t,
                             {r_owner, r_mem_addr, r_mem_wdata}, {1'b1, 5'h1F, 8'hC3});
                end
            end
        end
        r_ld_req = 1'b0;
        model_complete(1'b1, 5'h1F, 8'hC3, 1'b1);
        r_run(1'b1, 1'b0, 1'b0, 1'b0, 5'h1F, 5'h00, 8'h00, 8'h00);
        n_checks++;
        if (r_cpu_rdata !== 8'hC3 || r_ld_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL ld_write_readback: got %h/%h expected c3/00", r_cpu_rdata, r_ld_rdata);
        end
    endtask

    task automatic test_rr_tie();
        logic [AW-1:0] ta [2];
        bit w;
        ta[0] = 5'h1F; ta[1] = 5'h03;
        @(negedge clk);
        r_drive(1'b0, 1'b1, 1'b0, ta[0], 8'h00);
        r_drive(1'b1, 1'b1, 1'b0, ta[1], 8'h00);
        w = !m_last;
        for (int t = 1; t <= 6 * RPER; t++) begin
            int k;
            int ph;
            bit wk;
            k  = (t - 1) / RPER;
            ph = (t - 1) % RPER;
            wk = w ^ k[0];
            @(negedge clk);
            n_checks++;
            if ({r_cpu_ack, r_ld_ack} !== ((ph == RACC) ? (wk ? 2'b01 : 2'b10) : 2'b00)) begin
                n_fail++;
                $display("FAIL rr_tie_ack t=%0d: got %b expected winner %0d at phase %0d", t,
                         {r_cpu_ack, r_ld_ack}, wk, ph);
            end
            if (ph == 0) begin
                n_checks++;
                if ({r_owner, r_busy} !== {wk, 1'b1}) begin
                    n_fail++;
                    $display("FAIL rr_tie_owner t=%0d: got %b expected %b", t,
                             {r_owner, r_busy}, {wk, 1'b1});
                end
            end
            if (ph == RACC) begin
                model_complete(1'b0, ta[wk], 8'h00, wk);
                m_last = wk;
                n_checks++;
                if ({r_cpu_rdata, r_ld_rdata} !== {m_rdata[0], m_rdata[1]}) begin
                    n_fail++;
                    $display("FAIL rr_tie_rdata t=%0d: got %h expected %h", t,
                             {r_cpu_rdata, r_ld_rdata}, {m_rdata[0], m_rdata[1]});
                end
                if (k == 5) begin
                    r_cpu_req = 1'b0;
                    r_ld_req  = 1'b0;
                end
            end
        end
    endtask

    task automatic test_fixed_priority();
        int cpu_acks = 0;
        @(negedge clk);
        f_cpu_req = 1'b1; f_cpu_wr = 1'b0; f_cpu_addr = 5'h03;
        f_ld_req  = 1'b1; f_ld_wr  = 1'b0; f_ld_addr  = 5'h03;
        for (int t = 1; t <= 33; t++) begin
            @(negedge clk);
            n_checks++;
            if ({f_cpu_ack, f_ld_ack} !== {t <= 30 && t % 3 == 2, t == 32}) begin
                n_fail++;
                $display("FAIL fixed_prio t=%0d: got %b expected %b", t, {f_cpu_ack, f_ld_ack},
                         {t <= 30 && t % 3 == 2, t == 32});
            end
            if (f_cpu_ack) cpu_acks++;
            if (t == 29) f_cpu_req = 1'b0;
            if (t == 32) begin
                f_ld_req = 1'b0;
                n_checks++;
                if (f_ld_rdata !== 8'h5A) begin
                    n_fail++;
                    $display("FAIL fixed_prio_ld_rdata: got %h expected 5a", f_ld_rdata);
                end
            end
        end
        n_checks++;
        if (cpu_acks != 10) begin
            n_fail++;
            $display("FAIL fixed_prio_count: got %0d cpu acks expected 10", cpu_acks);
        end
    endtask

    task automatic test_req_drop();
        int acks = 0;
        @(negedge clk);
        r_drive(1'b0, 1'b1, 1'b0, 5'h1F, 8'h00);
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (r_cpu_ack) acks++;
            if (t == 2) r_drive(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
            if (t == 3) begin
                n_checks++;
                if ({r_mem_addr, r_mem_rd} !== {5'h1F, 1'b1}) begin
                    n_fail++;
                    $display("FAIL req_drop_addr: got %h expected %h", {r_mem_addr, r_mem_rd},
                             {5'h1F, 1'b1});
                end
            end
            if (t == 4) begin
                n_checks++;
                if ({r_cpu_ack, r_cpu_rdata} !== {1'b1, model_mem[31]}) begin
                    n_fail++;
                    $display("FAIL req_drop_ack: got %h expected %h", {r_cpu_ack, r_cpu_rdata},
                             {1'b1, model_mem[31]});
                end
            end
            if (t >= 6) begin
                n_checks++;
                if (r_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_drop_idle t=%0d: got busy %b expected 0", t, r_busy);
                end
            end
        end
        m_rdata[0] = model_mem[31];
        m_last = 1'b0;
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL req_drop_count: got %0d acks expected 1", acks);
        end
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            int sel;
            sel = $urandom_range(2, 0);
            r_run(sel != 1, sel != 0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  AW'($urandom_range(7, 0)), AW'($urandom_range(7, 0)),
                  DW'($urandom), DW'($urandom));
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        r_drive(1'b0, 1'b1, 1'b1, 5'h1F, ~model_mem[31]);
        for (int t = 1; t <= RACC; t++) begin
            @(negedge clk);
            n_checks++;
            if ({r_mem_oe, r_mem_wr} !== {1'b1, t == RACC}) begin
                n_fail++;
                $display("FAIL rst_write_strobe t=%0d: got %b expected %b", t,
                         {r_mem_oe, r_mem_wr}, {1'b1, t == RACC});
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({r_mem_wr, r_mem_oe, r_busy, r_cpu_ack, r_ld_ack} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_async: got %b expected 00000",
                     {r_mem_wr, r_mem_oe, r_busy, r_cpu_ack, r_ld_ack});
        end
        r_cpu_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({r_cpu_ack, r_ld_ack, r_busy} !== 3'b0) begin
                n_fail++;
                $display("FAIL rst_no_ack: got %b expected 000", {r_cpu_ack, r_ld_ack, r_busy});
            end
        end
        n_checks++;
        if (r_mem[31] !== model_mem[31]) begin
            n_fail++;
            $display("FAIL rst_mem_kept: got %h expected %h", r_mem[31], model_mem[31]);
        end
        rst = 1'b1;
        m_last = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        n_checks++;
        if ({r_cpu_rdata, r_ld_rdata, r_busy} !== '0) begin
            n_fail++;
            $display("FAIL rst_cleared: got %h expected 0", {r_cpu_rdata, r_ld_rdata, r_busy});
        end
        r_run(1'b1, 1'b1, 1'b0, 1'b0, 5'h1F, 5'h02, 8'h00, 8'h00);
    endtask

    task automatic test_memory_image();
        int bad = 0;
        for (int i = 0; i < 32; i++) if (r_mem[i] !== model_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL memory_image: got %0d differing words expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_loader_write();
        test_rr_tie();
        test_fixed_priority();
        test_req_drop();
        test_random(40);
        test_reset_mid_write();
        test_memory_image();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
